// File: rtl/wb_drain_ctrl.sv
// Drains the write-back buffer head onto the shared memory port and arbitrates
// that port against the load path, with starvation, full and flush overrides.
module wb_drain_ctrl #(
   parameter int STARVE_MAX = 4,
   parameter int CW         = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        wb_vld,
   input  logic [14:0] wb_addr,
   input  logic [31:0] wb_data,
   input  logic [2:0]  wb_size,
   input  logic        wb_empty,
   input  logic        wb_full,
   output logic        wb_read,
   input  logic        ld_req,
   input  logic [14:0] ld_addr,
   output logic        ld_done,
   output logic [31:0] ld_rdata,
   input  logic        flush_req,
   output logic        flush_done,
   output logic        mem_req,
   output logic        mem_we,
   output logic [14:0] mem_addr,
   output logic [31:0] mem_wdata,
   output logic [2:0]  mem_size,
   input  logic        mem_ack,
   input  logic [31:0] mem_rdata
);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      ST_WAIT = 2'd1,
      LD_WAIT = 2'd2
   } state_t;

   localparam logic [CW-1:0] STARVE_LIM = CW'(STARVE_MAX);
   localparam logic [2:0]    LD_SIZE    = 3'b100;

   state_t        r_state;
   logic [CW-1:0] r_starve;
   logic          r_ld_wb_vld;
   logic          r_mem_req;
   logic          r_mem_we;
   logic [14:0]   r_mem_addr;
   logic [31:0]   r_mem_wdata;
   logic [2:0]    r_mem_size;

   logic w_force_st;
   logic w_ld_ok;

   // A store is forced ahead of loads when the buffer is full, being flushed,
   // or the waiting head has already been passed over STARVE_MAX times.
   assign w_force_st = wb_vld & (wb_full | flush_req | (r_starve == STARVE_LIM));
   assign w_ld_ok    = ld_req & ~flush_req;

   // Completion strobes are decoded from the registered state so an
   // asynchronous reset kills them in the same cycle.
   assign wb_read    = (r_state == ST_WAIT) & mem_ack;
   assign ld_done    = (r_state == LD_WAIT) & mem_ack;
   assign ld_rdata   = mem_rdata;
   assign flush_done = flush_req & (r_state == IDLE) & wb_empty;

   assign mem_req    = r_mem_req;
   assign mem_we     = r_mem_we;
   assign mem_addr   = r_mem_addr;
   assign mem_wdata  = r_mem_wdata;
   assign mem_size   = r_mem_size;

   // NOTE: state and request registers use non-blocking assignments so every
   // decision in this block sees the values from before the clock edge.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state     <= IDLE;
         r_starve    <= '0;
         r_ld_wb_vld <= 1'b0;
         r_mem_req   <= 1'b0;
         r_mem_we    <= 1'b0;
         r_mem_addr  <= '0;
         r_mem_wdata <= '0;
         r_mem_size  <= '0;
      end else begin
         case (r_state)
            IDLE: begin
               if (w_force_st || (!w_ld_ok && wb_vld)) begin
                  r_mem_req   <= 1'b1;
                  r_mem_we    <= 1'b1;
                  r_mem_addr  <= wb_addr;
                  r_mem_wdata <= wb_data;
                  r_mem_size  <= wb_size;
                  r_state     <= ST_WAIT;
               end else if (w_ld_ok) begin
                  r_mem_req   <= 1'b1;
                  r_mem_we    <= 1'b0;
                  r_mem_addr  <= ld_addr;
                  r_mem_wdata <= '0;
                  r_mem_size  <= LD_SIZE;
                  r_ld_wb_vld <= wb_vld;
                  r_state     <= LD_WAIT;
               end
            end
            ST_WAIT: begin
               if (mem_ack) begin
                  r_mem_req <= 1'b0;
                  r_starve  <= '0;
                  r_state   <= IDLE;
               end
            end
            LD_WAIT: begin
               if (mem_ack) begin
                  r_mem_req <= 1'b0;
                  if (r_ld_wb_vld && (r_starve < STARVE_LIM))
                     r_starve <= r_starve + CW'(1);
                  r_state <= IDLE;
               end
            end
            default: begin
               r_mem_req <= 1'b0;
               r_state   <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_wb_drain_ctrl.sv
// Directed bench for wb_drain_ctrl: a buffer/memory model drives the DUT and a
// negedge monitor logs issues, pops and load completions for each scenario.
module tb_wb_drain_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic        wb_vld;
   logic [14:0] wb_addr;
   logic [31:0] wb_data;
   logic [2:0]  wb_size;
   logic        wb_empty;
   logic        wb_full;
   logic        wb_read;
   logic        ld_req;
   logic [14:0] ld_addr;
   logic        ld_done;
   logic [31:0] ld_rdata;
   logic        flush_req;
   logic        flush_done;
   logic        mem_req;
   logic        mem_we;
   logic [14:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [2:0]  mem_size;
   logic        mem_ack;
   logic [31:0] mem_rdata;

   wb_drain_ctrl #(.STARVE_MAX(4), .CW(4)) dut (
      .clk(clk), .rst(rst),
      .wb_vld(wb_vld), .wb_addr(wb_addr), .wb_data(wb_data), .wb_size(wb_size),
      .wb_empty(wb_empty), .wb_full(wb_full), .wb_read(wb_read),
      .ld_req(ld_req), .ld_addr(ld_addr), .ld_done(ld_done), .ld_rdata(ld_rdata),
      .flush_req(flush_req), .flush_done(flush_done),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_size(mem_size), .mem_ack(mem_ack), .mem_rdata(mem_rdata)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [14:0] a;
      logic [31:0] d;
      logic [2:0]  s;
   } ent_t;

   ent_t        q[$];
   bit          head_invalid = 1'b0;
   int          ack_lat = 3;
   logic [31:0] ld_val = '0;
   int          ld_left = 0;

   int          n_chk = 0;
   int          n_err = 0;
   int          n_pop, n_ldd, n_pop_noack, n_stab_err, n_fd_early;
   bit          issue_log[$];
   logic [14:0] cap_addr;
   logic [31:0] cap_data;
   logic [2:0]  cap_size;
   logic [31:0] last_rdata;
   bit          pop_flag = 1'b0;
   bit          ld_flag = 1'b0;
   bit          prev_req = 1'b0;

   function automatic void update_wb();
      wb_vld   = (q.size() > 0) && !head_invalid;
      wb_empty = (q.size() == 0);
      wb_full  = (q.size() >= 4);
      if (q.size() > 0) begin
         wb_addr = q[0].a;
         wb_data = q[0].d;
         wb_size = q[0].s;
      end else begin
         wb_addr = '0;
         wb_data = '0;
         wb_size = '0;
      end
   endfunction

   function automatic void push(input logic [14:0] a, input logic [31:0] d, input logic [2:0] s);
      ent_t e;
      e.a = a;
      e.d = d;
      e.s = s;
      q.push_back(e);
      update_wb();
   endfunction

   function automatic logic [15:0] pack_log();
      logic [15:0] v = '0;
      foreach (issue_log[i]) if (i < 16) v[i] = issue_log[i];
      return v;
   endfunction

   // Memory and buffer model: reacts just after each rising edge.
   initial begin
      int cnt = 0;
      mem_ack   = 1'b0;
      mem_rdata = '0;
      forever begin
         @(posedge clk);
         #1;
         if (rst) begin
            mem_ack  = 1'b0;
            cnt      = 0;
            pop_flag = 1'b0;
            ld_flag  = 1'b0;
         end else begin
            if (pop_flag) begin
               pop_flag = 1'b0;
               if (q.size() > 0) q.delete(0);
               update_wb();
            end
            if (ld_flag) begin
               ld_flag = 1'b0;
               if (ld_left > 0) ld_left--;
               if (ld_left == 0) ld_req = 1'b0;
            end
            if (mem_ack) begin
               mem_ack = 1'b0;
               cnt     = 0;
            end else if (mem_req) begin
               cnt++;
               if (cnt > ack_lat) begin
                  mem_ack   = 1'b1;
                  mem_rdata = mem_we ? 32'h0 : ld_val;
               end
            end
         end
      end
   end

   // Monitor: samples DUT outputs mid-cycle.
   initial begin
      forever begin
         @(negedge clk);
         if (rst) begin
            prev_req = 1'b0;
         end else begin
            if (wb_read) begin
               n_pop++;
               pop_flag = 1'b1;
               if (!mem_ack) n_pop_noack++;
            end
            if (ld_done) begin
               n_ldd++;
               ld_flag    = 1'b1;
               last_rdata = ld_rdata;
            end
            if (flush_done && q.size() != 0) n_fd_early++;
            if (mem_req && !prev_req) begin
               issue_log.push_back(mem_we);
               cap_addr = mem_addr;
               cap_data = mem_wdata;
               cap_size = mem_size;
            end else if (mem_req && (mem_addr !== cap_addr || mem_wdata !== cap_data ||
                                     mem_size !== cap_size)) begin
               n_stab_err++;
            end
            prev_req = mem_req;
         end
      end
   end

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #3;
   endtask

   task automatic clr();
      n_pop = 0; n_ldd = 0; n_pop_noack = 0; n_stab_err = 0; n_fd_early = 0;
      issue_log.delete();
   endtask

   task automatic start_loads(input int n, input logic [14:0] a);
      ld_left = n;
      ld_addr = a;
      ld_req  = 1'b1;
   endtask

   task automatic wait_pops(input int n, input int budget, input string name);
      int k = 0;
      while (n_pop < n && k < budget) begin
         tick(1);
         k++;
      end
      n_chk++;
      if (n_pop < n) begin
         n_err++;
         $display("FAIL %s: pops=%0d, expected %0d within %0d cycles", name, n_pop, n, budget);
      end
   endtask

   task automatic wait_ld(input int n, input int budget, input string name);
      int k = 0;
      while (n_ldd < n && k < budget) begin
         tick(1);
         k++;
      end
      n_chk++;
      if (n_ldd < n) begin
         n_err++;
         $display("FAIL %s: ld_done=%0d, expected %0d within %0d cycles", name, n_ldd, n, budget);
      end
   endtask

   task automatic test_reset();
      int k;
      rst = 1'b1; ld_req = 1'b0; ld_addr = '0; flush_req = 1'b0;
      update_wb();
      tick(2);
      n_chk++;
      if ({mem_req, mem_we, wb_read, ld_done, flush_done} !== 5'b0) begin
         n_err++;
         $display("FAIL reset_ctl: got %b, expected 00000",
                  {mem_req, mem_we, wb_read, ld_done, flush_done});
      end
      n_chk++;
      if (mem_addr !== 15'h0 || mem_wdata !== 32'h0 || mem_size !== 3'h0) begin
         n_err++;
         $display("FAIL reset_data: addr=%h wdata=%h size=%h, expected 0", mem_addr, mem_wdata, mem_size);
      end
      rst = 1'b0;
      tick(1);
      clr();
      ack_lat = 3;
      push(15'h0055, 32'hCAFE0001, 3'd2);
      k = 0;
      while (wb_read !== 1'b1 && k < 20) begin
         tick(1);
         k++;
      end
      n_chk++;
      if (wb_read !== 1'b1 || mem_req !== 1'b1) begin
         n_err++;
         $display("FAIL midrst_setup: wb_read=%b mem_req=%b, expected 1 1", wb_read, mem_req);
      end
      rst = 1'b1;
      #1;
      n_chk++;
      if (mem_req !== 1'b0 || wb_read !== 1'b0) begin
         n_err++;
         $display("FAIL midrst_out: mem_req=%b wb_read=%b, expected 0 0", mem_req, wb_read);
      end
      n_chk++;
      if (int'(dut.r_state) != 0 || dut.r_starve !== 4'd0) begin
         n_err++;
         $display("FAIL midrst_state: state=%0d starve=%0d, expected 0 0", int'(dut.r_state), dut.r_starve);
      end
      tick(2);
      n_chk++;
      if (n_pop != 0 || q.size() != 1) begin
         n_err++;
         $display("FAIL midrst_pop: pops=%0d entries=%0d, expected 0 1", n_pop, q.size());
      end
      q.delete();
      update_wb();
      rst = 1'b0;
      tick(2);
   endtask

   task automatic test_single_store();
      clr();
      ack_lat = 3;
      push(15'h0123, 32'hDEADBEEF, 3'd4);
      wait_pops(1, 30, "store_pop");
      tick(6);
      n_chk++;
      if (issue_log.size() != 1 || pack_log() !== 16'h0001) begin
         n_err++;
         $display("FAIL store_issue: count=%0d log=%h, expected 1 0001", issue_log.size(), pack_log());
      end
      n_chk++;
      if (cap_addr !== 15'h0123 || cap_data !== 32'hDEADBEEF || cap_size !== 3'd4) begin
         n_err++;
         $display("FAIL store_fields: %h %h %h, expected 0123 deadbeef 4", cap_addr, cap_data, cap_size);
      end
      n_chk++;
      if (n_stab_err != 0) begin
         n_err++;
         $display("FAIL store_stable: unstable cycles=%0d, expected 0", n_stab_err);
      end
      n_chk++;
      if (n_pop != 1 || n_pop_noack != 0) begin
         n_err++;
         $display("FAIL store_pulse: pops=%0d without_ack=%0d, expected 1 0", n_pop, n_pop_noack);
      end
   endtask

   task automatic test_starve();
      clr();
      ack_lat = 2;
      ld_val  = 32'hA5A5_0000;
      push(15'h0200, 32'h11110000, 3'd3);
      start_loads(5, 15'h0300);
      wait_ld(5, 200, "starve_loads");
      tick(4);
      n_chk++;
      if (issue_log.size() != 6 || pack_log() !== 16'h0010) begin
         n_err++;
         $display("FAIL starve_order: count=%0d log=%h, expected 6 0010", issue_log.size(), pack_log());
      end
      n_chk++;
      if (n_pop != 1 || dut.r_starve !== 4'd0) begin
         n_err++;
         $display("FAIL starve_clear: pops=%0d starve=%0d, expected 1 0", n_pop, dut.r_starve);
      end
   endtask

   task automatic test_full_vs_load();
      clr();
      ack_lat = 1;
      push(15'h0400, 32'h0000_0001, 3'd2);
      push(15'h0401, 32'h0000_0002, 3'd2);
      push(15'h0402, 32'h0000_0003, 3'd2);
      push(15'h0403, 32'h0000_0004, 3'd2);
      start_loads(1, 15'h0500);
      wait_pops(4, 200, "full_pops");
      wait_ld(1, 50, "full_load");
      tick(4);
      n_chk++;
      if (issue_log.size() != 5 || pack_log() !== 16'h001D) begin
         n_err++;
         $display("FAIL full_order: count=%0d log=%h, expected 5 001d", issue_log.size(), pack_log());
      end
      n_chk++;
      if (cap_addr !== 15'h0403 || cap_data !== 32'h0000_0004) begin
         n_err++;
         $display("FAIL full_last: addr=%h data=%h, expected 0403 00000004", cap_addr, cap_data);
      end
      n_chk++;
      if (dut.r_starve !== 4'd0 || n_stab_err != 0) begin
         n_err++;
         $display("FAIL full_misc: starve=%0d unstable=%0d, expected 0 0", dut.r_starve, n_stab_err);
      end
   endtask

   task automatic test_head_invalid();
      clr();
      ack_lat = 2;
      ld_val  = 32'h12345678;
      head_invalid = 1'b1;
      push(15'h0600, 32'hBBBB0000, 3'd1);
      start_loads(1, 15'h0700);
      tick(12);
      n_chk++;
      if (issue_log.size() != 1 || pack_log() !== 16'h0000 || cap_size !== 3'b100) begin
         n_err++;
         $display("FAIL inval_issue: count=%0d log=%h size=%b, expected 1 0000 100",
                  issue_log.size(), pack_log(), cap_size);
      end
      n_chk++;
      if (n_ldd != 1 || last_rdata !== 32'h12345678) begin
         n_err++;
         $display("FAIL inval_load: done=%0d rdata=%h, expected 1 12345678", n_ldd, last_rdata);
      end
      n_chk++;
      if (n_pop != 0) begin
         n_err++;
         $display("FAIL inval_pop: pops=%0d, expected 0", n_pop);
      end
      head_invalid = 1'b0;
      update_wb();
      wait_pops(1, 30, "inval_drain");
      tick(3);
   endtask

   task automatic test_flush();
      clr();
      ack_lat = 2;
      ld_val  = 32'h0F0F0F0F;
      flush_req = 1'b1;
      push(15'h0010, 32'h0000_00A0, 3'd2);
      push(15'h0011, 32'h0000_00A1, 3'd2);
      push(15'h0012, 32'h0000_00A2, 3'd2);
      start_loads(1, 15'h0800);
      wait_pops(3, 200, "flush_pops");
      tick(3);
      n_chk++;
      if (issue_log.size() != 3 || pack_log() !== 16'h0007 || n_ldd != 0) begin
         n_err++;
         $display("FAIL flush_order: count=%0d log=%h loads=%0d, expected 3 0007 0",
                  issue_log.size(), pack_log(), n_ldd);
      end
      n_chk++;
      if (flush_done !== 1'b1 || n_fd_early != 0) begin
         n_err++;
         $display("FAIL flush_done: done=%b early=%0d, expected 1 0", flush_done, n_fd_early);
      end
      flush_req = 1'b0;
      wait_ld(1, 50, "flush_load");
      tick(2);
      n_chk++;
      if (issue_log.size() != 4 || pack_log() !== 16'h0007 || flush_done !== 1'b0) begin
         n_err++;
         $display("FAIL flush_after: count=%0d log=%h done=%b, expected 4 0007 0",
                  issue_log.size(), pack_log(), flush_done);
      end
   endtask

   initial begin
      test_reset();
      test_single_store();
      test_starve();
      test_full_vs_load();
      test_head_invalid();
      test_flush();
      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

endmodule

// File: doc/wb_drain_ctrl.md
Name: wb_drain_ctrl

Overview:
Sequences the 4-entry write-back buffer onto the single shared cache/mem port and arbitrates that port against the load path. Stores drain in order from the buffer head. The head is popped only after memory acknowledges the write. Loads normally have priority; a starvation counter, a full buffer, or a flush request forces drains instead.

Parameters:
STARVE_MAX, 4, consecutive load grants allowed while a valid store is waiting before a store is forced (1..15)
CW, 4, width of the starvation counter

Ports:
clk  in  1  clock; all state changes on rising edge
rst  in  1  asynchronous, active-high reset
wb_vld  in  1  head entry of write-back buffer is allocated and valid
wb_addr  in  15  head entry address
wb_data  in  32  head entry data
wb_size  in  3  head entry size
wb_empty  in  1  write-back buffer empty
wb_full  in  1  write-back buffer full
wb_read  out  1  pop pulse to write-back buffer
ld_req  in  1  load request; level, held until ld_done
ld_addr  in  15  load address
ld_done  out  1  one-cycle pulse: load data valid on ld_rdata
ld_rdata  out  32  load data; passthrough of mem_rdata
flush_req  in  1  level; drain buffer and block loads
flush_done  out  1  buffer drained under flush
mem_req  out  1  memory request
mem_we  out  1  1 = store, 0 = load
mem_addr  out  15  request address
mem_wdata  out  32  store data
mem_size  out  3  store size; 3'b100 for loads
mem_ack  in  1  one-cycle completion from memory, at least 1 cycle after mem_req
mem_rdata  in  32  load data, valid with mem_ack

Behaviour:
- Reset values:
  - state = IDLE, starve counter = 0.
  - mem_req, mem_we, wb_read, ld_done, flush_done = 0.
  - mem_addr, mem_wdata = 0; mem_size = 0.
- FSM states: IDLE, ST_WAIT, LD_WAIT.
- IDLE arbitration, evaluated each cycle in priority order:
  1. force_st = wb_vld & (wb_full | flush_req | starve == STARVE_MAX). If set, issue store and go to ST_WAIT.
  2. Else if ld_req & !flush_req, issue load and go to LD_WAIT.
  3. Else if wb_vld, issue store and go to ST_WAIT.
  4. Else stay in IDLE.
- Issue mechanics:
  - mem_* outputs are registered; mem_req rises the cycle after the IDLE decision.
  - Address, data and size are captured at issue and held stable until mem_ack.
  - mem_req stays high through the mem_ack cycle, then deasserts (no back-to-back issue from the same state).
- Head entry allocated but not valid (wb_vld = 0, wb_empty = 0):
  - Never issued and never popped.
  - Controller waits; loads may proceed.
- ST_WAIT:
  - On mem_ack: wb_read = 1 for that cycle only (combinational from state & mem_ack), starve cleared to 0, next state IDLE.
  - Exactly one pop per acknowledged store.
- LD_WAIT:
  - On mem_ack: ld_done = 1 for that cycle, ld_rdata = mem_rdata, next state IDLE.
  - starve increments (saturating at STARVE_MAX) if wb_vld was high at issue.
- Starve counter:
  - Width CW, saturating.
  - Cleared only on store completion or reset.
- Flush:
  - While flush_req = 1, no new load issues; an in-flight load completes normally.
  - flush_done = 1 (combinational) when flush_req & state == IDLE & wb_empty.
- Simultaneous events:
  - wb_full and ld_req together: store wins.
  - mem_ack while in IDLE: ignored.
- Reset mid-transaction: all outputs return to reset values immediately (asynchronous); the in-flight request is abandoned and the buffer is not popped.

Test Plan:
- Reset with mem_req high in ST_WAIT -> mem_req, wb_read drop to 0 that cycle; state IDLE; no pop.
- Single store (wb_vld = 1, addr 15'h0123, data 32'hDEADBEEF, size 4, no loads), mem_ack 3 cycles after mem_req -> mem_we = 1; fields stable; exactly one wb_read pulse coincident with mem_ack.
- ld_req held, wb_vld = 1, wb_full = 0, STARVE_MAX = 4 -> 4 loads granted (4 ld_done pulses), 5th grant is a store, then starve = 0.
- wb_full = 1 and ld_req = 1 in the same IDLE cycle -> store issued first; load issued only after that store's ack.
- Head allocated but not valid (wb_vld = 0, wb_empty = 0) for 10 cycles -> no store issued, no wb_read; a concurrent load completes with ld_rdata = 32'h12345678.
- flush_req = 1 with 3 valid entries plus a pending load -> 3 store acks and 3 pops, no load issued; flush_done = 1 once wb_empty; load issues after flush_req drops.
